// File: rtl/id_stage.sv
// Instruction-decode stage: combinational ARM decode, condition evaluation and
// the R0..R14 register file written by writeback.
module id_stage #(
  parameter int unsigned REG_COUNT = 15,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [31:0]       instruction,
  input  logic [3:0]        status,
  input  logic              hazard,
  input  logic              wb_wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic [DATA_W-1:0] pc_out,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              b,
  output logic              s,
  output logic [3:0]        exe_cmd,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic              imm,
  output logic [11:0]       shift_operand,
  output logic [23:0]       signed_imm_24,
  output logic [3:0]        dest,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic              two_src
);

  localparam int unsigned IDX_W  = 4;
  localparam logic [IDX_W-1:0] PC_IDX = 4'd15;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  logic [DATA_W-1:0] regs [REG_COUNT];

  logic [1:0] mode;
  logic [3:0] opcode;
  logic       s_bit;
  logic       store;
  logic       cond_pass;
  logic       bubble;

  logic [3:0] cmd_d;
  logic       wb_d;
  logic       mr_d;
  logic       mw_d;
  logic       br_d;
  logic       s_d;

  assign mode   = instruction[27:26];
  assign opcode = instruction[24:21];
  assign s_bit  = instruction[20];
  assign store  = (mode == MODE_MEM) && !s_bit;

  // Register file; index 15 is the PC and is never stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_wb_en && (wb_dest != PC_IDX) && (32'(wb_dest) < REG_COUNT)) begin
      regs[wb_dest] <= wb_value;
    end
  end

  // PC read wins over the bypass, since writes to index 15 are dropped.
  function automatic logic [DATA_W-1:0] read_reg(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    if (idx == PC_IDX)                 v = pc_in;
    else if (wb_wb_en && wb_dest == idx) v = wb_value;
    else if (32'(idx) < REG_COUNT)     v = regs[idx];
    return v;
  endfunction

  assign src1    = instruction[19:16];
  assign src2    = store ? instruction[15:12] : instruction[3:0];
  assign two_src = ~instruction[25] | store;

  always_comb begin
    val_rn = read_reg(src1);
    val_rm = read_reg(src2);
  end

  // Control decode before condition/bubble masking.
  always_comb begin
    cmd_d = 4'b0000;
    wb_d  = 1'b0;
    mr_d  = 1'b0;
    mw_d  = 1'b0;
    br_d  = 1'b0;
    s_d   = 1'b0;
    case (mode)
      MODE_DP: begin
        wb_d = 1'b1;
        s_d  = s_bit;
        case (opcode)
          OP_MOV: cmd_d = CMD_MOV;
          OP_MVN: cmd_d = CMD_MVN;
          OP_ADD: cmd_d = CMD_ADD;
          OP_ADC: cmd_d = CMD_ADC;
          OP_SUB: cmd_d = CMD_SUB;
          OP_SBC: cmd_d = CMD_SBC;
          OP_AND: cmd_d = CMD_AND;
          OP_ORR: cmd_d = CMD_ORR;
          OP_EOR: cmd_d = CMD_EOR;
          OP_CMP: begin
            cmd_d = CMD_SUB;
            wb_d  = 1'b0;
            s_d   = 1'b1;
          end
          OP_TST: begin
            cmd_d = CMD_AND;
            wb_d  = 1'b0;
            s_d   = 1'b1;
          end
          default: begin
            wb_d = 1'b0;
            s_d  = 1'b0;
          end
        endcase
      end
      MODE_MEM: begin
        cmd_d = CMD_ADD;
        if (s_bit) begin
          mr_d = 1'b1;
          wb_d = 1'b1;
        end else begin
          mw_d = 1'b1;
        end
      end
      MODE_BR: br_d = 1'b1;
      default: ;
    endcase
  end

  // Condition field against {N,Z,C,V}.
  always_comb begin
    logic n, z, c, v;
    n = status[3];
    z = status[2];
    c = status[1];
    v = status[0];
    cond_pass = 1'b0;
    case (instruction[31:28])
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c && !z;
      4'b1001: cond_pass = !c || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // An all-zero word marks a flushed slot.
  assign bubble = !cond_pass || hazard || (instruction == 32'h0);

  assign wb_en    = wb_d & ~bubble;
  assign mem_r_en = mr_d & ~bubble;
  assign mem_w_en = mw_d & ~bubble;
  assign b        = br_d & ~bubble;
  assign s        = s_d  & ~bubble;
  assign exe_cmd  = cmd_d;

  assign pc_out        = pc_in;
  assign imm           = instruction[25];
  assign shift_operand = instruction[11:0];
  assign signed_imm_24 = instruction[23:0];
  assign dest          = instruction[15:12];

endmodule
